rf_access_ctrl: RTL and testbench

Register-file access sequencer, directly upstream of REGISTER_FILE_32x32.
- Accepts operand-read requests (two source addresses) and writeback requests (destination address + data) from the pipeline.
- Buffers writebacks in a small FIFO, serialises RF read/write strobes, and captures read data.
- Presents the operand pair downstream with a valid/ready handshake.

---
 rtl/rf_access_ctrl_pkg.sv | 15 +
 rtl/rf_wb_fifo.sv | 76 +++++++
 rtl/rf_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_rf_access_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_ctrl_pkg.sv
// Shared widths and sequencer state encoding for the register-file access controller.
package rf_access_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback buffer: circular FIFO of (address, data) pairs draining in arrival order.
// With RF_BYPASS_EN it also exposes every entry, ordered oldest to newest, for operand forwarding.
module rf_wb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WB_DEPTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [ADDR_WIDTH-1:0]                push_addr,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic                                 pop,
`ifdef RF_BYPASS_EN
    output logic [WB_DEPTH-1:0]                  entry_valid,
    output logic [WB_DEPTH-1:0][ADDR_WIDTH-1:0]  entry_addr,
    output logic [WB_DEPTH-1:0][DATA_WIDTH-1:0]  entry_data,
`endif
    output logic                                 full,
    output logic                                 empty,
    output logic [ADDR_WIDTH-1:0]                head_addr,
    output logic [DATA_WIDTH-1:0]                head_data
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0] DEPTH_CNT = CW'(WB_DEPTH);

    logic [ADDR_WIDTH-1:0] addr_mem [WB_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [WB_DEPTH];
    logic [PW:0]           wr_ptr_reg;
    logic [PW:0]           rd_ptr_reg;
    logic [PW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_reg[PW-1:0]] <= push_addr;
            data_mem[wr_ptr_reg[PW-1:0]] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr_reg[PW-1:0]];
    assign head_data = data_mem[rd_ptr_reg[PW-1:0]];

`ifdef RF_BYPASS_EN
    generate
        for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_view
            logic [PW-1:0] idx;
            assign idx             = rd_ptr_reg[PW-1:0] + PW'(gi);
            assign entry_valid[gi] = (CW'(gi) < count);
            assign entry_addr[gi]  = addr_mem[idx];
            assign entry_data[gi]  = data_mem[idx];
        end
    endgenerate
`endif

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: buffers writebacks, serialises RF strobes, returns operand pairs.
// Define RF_BYPASS_EN for read-priority scheduling with forwarding from buffered writebacks.
module rf_access_ctrl #(
    parameter int DATA_WIDTH = rf_access_ctrl_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_access_ctrl_pkg::ADDR_WIDTH,
    parameter int WB_DEPTH   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RQ_VALID,
    output logic                  RQ_READY,
    input  logic [ADDR_WIDTH-1:0] RQ_ADDR1,
    input  logic [ADDR_WIDTH-1:0] RQ_ADDR2,
    output logic                  OP_VALID,
    input  logic                  OP_READY,
    output logic [DATA_WIDTH-1:0] OP_DATA1,
    output logic [DATA_WIDTH-1:0] OP_DATA2,
    input  logic                  WB_VALID,
    output logic                  WB_READY,
    input  logic [ADDR_WIDTH-1:0] WB_ADDR,
    input  logic [DATA_WIDTH-1:0] WB_DATA,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic                  RF_READ,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    output logic                  RF_WRITE
);

    import rf_access_ctrl_pkg::*;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr1_reg;
    logic [ADDR_WIDTH-1:0] addr2_reg;
    logic [DATA_WIDTH-1:0] op_data1_reg;
    logic [DATA_WIDTH-1:0] op_data2_reg;
    logic [DATA_WIDTH-1:0] cap_data1;
    logic [DATA_WIDTH-1:0] cap_data2;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
`ifdef RF_BYPASS_EN
    logic [WB_DEPTH-1:0]                 entry_valid;
    logic [WB_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;
    logic [WB_DEPTH-1:0][DATA_WIDTH-1:0] entry_data;
`endif

    // r0 is hard-wired zero: the handshake completes but nothing is buffered.
    assign WB_READY  = !fifo_full;
    assign fifo_push = WB_VALID && WB_READY && (WB_ADDR != '0);
    assign fifo_pop  = (state_reg == ST_WR);

    rf_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WB_DEPTH   (WB_DEPTH)
    ) u_wb_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push        (fifo_push),
        .push_addr   (WB_ADDR),
        .push_data   (WB_DATA),
        .pop         (fifo_pop),
`ifdef RF_BYPASS_EN
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
`endif
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_addr   (head_addr),
        .head_data   (head_data)
    );

`ifdef RF_BYPASS_EN
    assign RQ_READY = (state_reg == ST_IDLE) && !fifo_full;
`else
    assign RQ_READY = (state_reg == ST_IDLE) && fifo_empty;
`endif

    // Operand capture source; later (newer) matches override older ones.
    always_comb begin
        cap_data1 = RF_DATA_R1;
        cap_data2 = RF_DATA_R2;
`ifdef RF_BYPASS_EN
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (entry_valid[k] && (entry_addr[k] != '0) && (entry_addr[k] == addr1_reg))
                cap_data1 = entry_data[k];
            if (entry_valid[k] && (entry_addr[k] != '0) && (entry_addr[k] == addr2_reg))
                cap_data2 = entry_data[k];
        end
        if (fifo_push && (WB_ADDR == addr1_reg)) cap_data1 = WB_DATA;
        if (fifo_push && (WB_ADDR == addr2_reg)) cap_data2 = WB_DATA;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            addr1_reg    <= '0;
            addr2_reg    <= '0;
            op_data1_reg <= '0;
            op_data2_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
`ifdef RF_BYPASS_EN
                    if (fifo_full) begin
                        state_reg <= ST_WR;
                    end else if (RQ_VALID) begin
                        state_reg <= ST_RD;
                        addr1_reg <= RQ_ADDR1;
                        addr2_reg <= RQ_ADDR2;
                    end else if (!fifo_empty) begin
                        state_reg <= ST_WR;
                    end
`else
                    if (!fifo_empty) begin
                        state_reg <= ST_WR;
                    end else if (RQ_VALID) begin
                        state_reg <= ST_RD;
                        addr1_reg <= RQ_ADDR1;
                        addr2_reg <= RQ_ADDR2;
                    end
`endif
                end
                ST_WR:  state_reg <= ST_IDLE;
                ST_RD:  state_reg <= ST_CAP;
                ST_CAP: begin
                    op_data1_reg <= cap_data1;
                    op_data2_reg <= cap_data2;
                    state_reg    <= ST_OUT;
                end
                ST_OUT: if (OP_READY) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign OP_VALID   = (state_reg == ST_OUT);
    assign OP_DATA1   = op_data1_reg;
    assign OP_DATA2   = op_data2_reg;
    assign RF_READ    = (state_reg == ST_RD);
    assign RF_ADDR_R1 = RF_READ ? addr1_reg : '0;
    assign RF_ADDR_R2 = RF_READ ? addr2_reg : '0;
    assign RF_WRITE   = (state_reg == ST_WR);
    assign RF_ADDR_W  = RF_WRITE ? head_addr : '0;
    assign RF_DATA_W  = RF_WRITE ? head_data : '0;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed testbench for rf_access_ctrl with a behavioural 32x32 register file attached.
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq_valid, rq_ready;
    logic [4:0]  rq_addr1, rq_addr2;
    logic        op_valid, op_ready;
    logic [31:0] op_data1, op_data2;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
    logic        rf_read, rf_write;
    logic [31:0] rf_data_r1, rf_data_r2, rf_data_w;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rf_mem [32];
    int          write_count = 0;
    logic        prev_write = 1'b0;
    logic        double_write = 1'b0;
    logic [4:0]  wlog_addr [$];
    logic [31:0] wlog_data [$];

    always #5 clk = ~clk;

    rf_access_ctrl dut (
        .CLK        (clk),
        .RST        (rst),
        .RQ_VALID   (rq_valid),
        .RQ_READY   (rq_ready),
        .RQ_ADDR1   (rq_addr1),
        .RQ_ADDR2   (rq_addr2),
        .OP_VALID   (op_valid),
        .OP_READY   (op_ready),
        .OP_DATA1   (op_data1),
        .OP_DATA2   (op_data2),
        .WB_VALID   (wb_valid),
        .WB_READY   (wb_ready),
        .WB_ADDR    (wb_addr),
        .WB_DATA    (wb_data),
        .RF_ADDR_R1 (rf_addr_r1),
        .RF_ADDR_R2 (rf_addr_r2),
        .RF_READ    (rf_read),
        .RF_DATA_R1 (rf_data_r1),
        .RF_DATA_R2 (rf_data_r2),
        .RF_ADDR_W  (rf_addr_w),
        .RF_DATA_W  (rf_data_w),
        .RF_WRITE   (rf_write)
    );

    // Register file model: samples strobes at the rising edge, read data valid after it.
    always @(posedge clk) begin
        if (rf_read) begin
            rf_data_r1 <= rf_mem[rf_addr_r1];
            rf_data_r2 <= rf_mem[rf_addr_r2];
        end
        if (rf_write) begin
            rf_mem[rf_addr_w] <= rf_data_w;
            write_count = write_count + 1;
            wlog_addr.push_back(rf_addr_w);
            wlog_data.push_back(rf_data_w);
        end
        if (rf_write && prev_write) double_write = 1'b1;
        prev_write = rf_write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        while (!wb_ready && n < 50) begin tick(); n++; end
        compared++;
        if (n >= 50) begin
            mismatched++;
            $display("FAIL wb_accept_timeout addr=%0d got WB_READY=%b want 1", a, wb_ready);
        end
        tick();
        wb_valid = 1'b0;
        $display("WB   r%0d <= %h (waited %0d)", a, d, n);
    endtask

    task automatic do_req(input logic [4:0] a1, input logic [4:0] a2,
                          output logic [31:0] d1, output logic [31:0] d2);
        int n = 0;
        rq_valid = 1'b1; rq_addr1 = a1; rq_addr2 = a2;
        while (!rq_ready && n < 50) begin tick(); n++; end
        tick();
        rq_valid = 1'b0;
        while (!op_valid && n < 100) begin tick(); n++; end
        compared++;
        if (n >= 100) begin
            mismatched++;
            $display("FAIL req_timeout (%0d,%0d) got OP_VALID=%b want 1", a1, a2, op_valid);
        end
        d1 = op_data1; d2 = op_data2;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        $display("REQ  (%0d,%0d) -> %h %h", a1, a2, d1, d2);
    endtask

    task automatic test_reset();
        compared++;
        if ({op_valid, rf_read, rf_write, rq_ready, wb_ready} !== 5'b00011) begin
            mismatched++;
            $display("FAIL reset_ctrl got %b want 00011",
                     {op_valid, rf_read, rf_write, rq_ready, wb_ready});
        end
        compared++;
        if ({op_data1, op_data2} !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_opdata got %h %h want 0 0", op_data1, op_data2);
        end
        $display("RST  outputs checked");
    endtask

    task automatic test_write_read();
        logic [31:0] d1, d2;
        int wc0 = write_count;
        for (int i = 1; i <= 9; i++) do_wb(5'(i), 32'(2 * i));
        for (int i = 1; i <= 9; i++) begin
            do_req(5'(i), 5'(10 - i), d1, d2);
            compared++;
            if (d1 !== 32'(2 * i) || d2 !== 32'(2 * (10 - i))) begin
                mismatched++;
                $display("FAIL wr_rd_%0d got %h %h want %h %h", i, d1, d2,
                         32'(2 * i), 32'(2 * (10 - i)));
            end
        end
        compared++;
        if (write_count - wc0 !== 9 || double_write !== 1'b0) begin
            mismatched++;
            $display("FAIL write_pulses got count=%0d double=%b want 9 0",
                     write_count - wc0, double_write);
        end
    endtask

    task automatic test_latency();
        int n = 0;
        logic [31:0] h1, h2;
        rq_valid = 1'b1; rq_addr1 = 5'd3; rq_addr2 = 5'd4;
        while (!rq_ready && n < 50) begin tick(); n++; end
        tick();
        rq_valid = 1'b0;
        compared++;
        if ({rf_read, op_valid, rq_ready} !== 3'b100 || rf_addr_r1 !== 5'd3 || rf_addr_r2 !== 5'd4) begin
            mismatched++;
            $display("FAIL lat_e0 got rd/ov/rr=%b a=%0d,%0d want 100 a=3,4",
                     {rf_read, op_valid, rq_ready}, rf_addr_r1, rf_addr_r2);
        end
        tick();
        compared++;
        if ({rf_read, op_valid} !== 2'b00) begin
            mismatched++;
            $display("FAIL lat_e1 got rd/ov=%b want 00", {rf_read, op_valid});
        end
        tick();
        compared++;
        if (op_valid !== 1'b1 || op_data1 !== 32'd6 || op_data2 !== 32'd8) begin
            mismatched++;
            $display("FAIL lat_e2 got ov=%b %h %h want 1 6 8", op_valid, op_data1, op_data2);
        end
        h1 = op_data1; h2 = op_data2;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (op_valid !== 1'b1 || rq_ready !== 1'b0 || op_data1 !== h1 || op_data2 !== h2) begin
                mismatched++;
                $display("FAIL hold_%0d got ov=%b rr=%b %h %h want 1 0 6 8",
                         c, op_valid, rq_ready, op_data1, op_data2);
            end
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        $display("LAT  (3,4) -> %h %h held 5 cycles", h1, h2);
    endtask

    task automatic test_fifo_full();
        int n = 0;
        int wc0;
        rq_valid = 1'b1; rq_addr1 = 5'd1; rq_addr2 = 5'd2;
        while (!rq_ready && n < 50) begin tick(); n++; end
        tick();
        rq_valid = 1'b0;
        tick(); tick();
        wc0 = write_count;
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'd100;
        tick();
        wb_addr = 5'd11; wb_data = 32'd110;
        tick();
        compared++;
        if (wb_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL fifo_full got WB_READY=%b want 0", wb_ready);
        end
        wb_addr = 5'd12; wb_data = 32'd120;
        tick(); tick();
        compared++;
        if (wb_ready !== 1'b0 || op_valid !== 1'b1 || write_count !== wc0 || op_data1 !== 32'd2) begin
            mismatched++;
            $display("FAIL fifo_stall got wr=%b ov=%b writes=%0d d1=%h want 0 1 0 2",
                     wb_ready, op_valid, write_count - wc0, op_data1);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        n = 0;
        while (wb_valid && n < 30) begin
            if (wb_ready) begin tick(); wb_valid = 1'b0; end
            else begin tick(); n++; end
        end
        while (write_count < wc0 + 3 && n < 60) begin tick(); n++; end
        tick();
        compared++;
        if (write_count !== wc0 + 3) begin
            mismatched++;
            $display("FAIL drain_count got %0d want 3", write_count - wc0);
        end else begin
            compared++;
            if (wlog_addr[wc0] !== 5'd10 || wlog_data[wc0] !== 32'd100 ||
                wlog_addr[wc0+1] !== 5'd11 || wlog_data[wc0+1] !== 32'd110 ||
                wlog_addr[wc0+2] !== 5'd12 || wlog_data[wc0+2] !== 32'd120) begin
                mismatched++;
                $display("FAIL drain_order got r%0d=%0d r%0d=%0d r%0d=%0d want r10=100 r11=110 r12=120",
                         wlog_addr[wc0], wlog_data[wc0], wlog_addr[wc0+1], wlog_data[wc0+1],
                         wlog_addr[wc0+2], wlog_data[wc0+2]);
            end
        end
        compared++;
        if (wb_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL drain_ready got WB_READY=%b want 1", wb_ready);
        end
        $display("FULL fifo filled, stalled and drained");
    endtask

    task automatic test_r0_discard();
        int wc0 = write_count;
        do_wb(5'd0, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) tick();
        compared++;
        if (write_count !== wc0 || rq_ready !== 1'b1 || wb_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL r0_discard got writes=%0d rr=%b wr=%b want 0 1 1",
                     write_count - wc0, rq_ready, wb_ready);
        end
        $display("R0   write discarded");
    endtask

    task automatic test_reset_cap();
        logic [31:0] d1, d2;
        int n = 0;
        int wc0;
        rq_valid = 1'b1; rq_addr1 = 5'd5; rq_addr2 = 5'd6;
        while (!rq_ready && n < 50) begin tick(); n++; end
        tick();
        rq_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'd777;
        tick();
        wb_valid = 1'b0;
        wc0 = write_count;
        rst = 1'b1;
        #1;
        compared++;
        if ({op_valid, rf_write, rf_read, rq_ready} !== 4'b0001 || op_data1 !== 32'd0) begin
            mismatched++;
            $display("FAIL rst_cap got ov/wr/rd/rr=%b d1=%h want 0001 0",
                     {op_valid, rf_write, rf_read, rq_ready}, op_data1);
        end
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        compared++;
        if (write_count !== wc0 || rf_mem[7] === 32'd777) begin
            mismatched++;
            $display("FAIL rst_fifo_flush got writes=%0d r7=%0d want 0 !777",
                     write_count - wc0, rf_mem[7]);
        end
        do_req(5'd5, 5'd6, d1, d2);
        compared++;
        if (d1 !== 32'd10 || d2 !== 32'd12) begin
            mismatched++;
            $display("FAIL rst_recover got %h %h want a c", d1, d2);
        end
    endtask

`ifdef RF_BYPASS_EN
    task automatic test_bypass();
        int n = 0;
        int wc0;
        while (!rq_ready && n < 50) begin tick(); n++; end
        wc0 = write_count;
        rq_valid = 1'b1; rq_addr1 = 5'd5; rq_addr2 = 5'd5;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        rq_valid = 1'b0; wb_valid = 1'b0;
        while (!op_valid && n < 100) begin tick(); n++; end
        compared++;
        if (op_data1 !== 32'h1234 || op_data2 !== 32'h1234 || write_count !== wc0) begin
            mismatched++;
            $display("FAIL bypass got %h %h writes=%0d want 1234 1234 0",
                     op_data1, op_data2, write_count - wc0);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        $display("BYP  (5,5) -> %h %h", op_data1, op_data2);
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_data_r1 = '0; rf_data_r2 = '0;
        rst = 1'b1;
        rq_valid = 1'b0; rq_addr1 = '0; rq_addr2 = '0;
        op_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_write_read();
        test_latency();
        test_fifo_full();
        test_r0_discard();
        test_reset_cap();
`ifdef RF_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
